// File: rtl/tff_read_decoder_pkg.sv
// Shared definitions for the TFF read-out path: FSM state encodings and the
// default widths that the upstream encoder and this decoder must agree on.
package tff_read_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DONE  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   localparam int DEF_CNT_BITS    = 8;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/tff_read_decoder_bit_sync.sv
// N-flop synchronizer for a single asynchronous bit, synchronously cleared to 0.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule

// File: rtl/tff_read_decoder.sv
// Read-out stage for the TFF delay ring: clears the ring, times the rising edge
// of its output in clk cycles, and hands the result to a consumer via valid/ack.
module tff_read_decoder
   import tff_read_decoder_pkg::*;
#(
   parameter int CNT_BITS    = DEF_CNT_BITS,
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CLR_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                ack,
   input  logic                tff_out,
   input  logic                tff_carry,
   output logic                RE,
   output logic                rstb,
   output logic                busy,
   output logic                valid,
   output logic [CNT_BITS-1:0] value,
   output logic                overflow,
   output logic                timeout
);

   localparam int                  CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CLR_W-1:0]    CLR_LAST = CLR_W'(CLR_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] TO_VAL   = CNT_BITS'(TIMEOUT);
   localparam logic [CNT_BITS-1:0] SYNC_OFS = CNT_BITS'(SYNC_STAGES);

   // The edge is seen SYNC_STAGES cycles late; remove that bias, never going below 0.
   function automatic logic [CNT_BITS-1:0] sat_sub_sync(input logic [CNT_BITS-1:0] a);
      if (a < SYNC_OFS) begin
         return '0;
      end
      return a - SYNC_OFS;
   endfunction

   logic                w_out_s;
   logic                w_carry_s;

   state_t              r_state,    w_state_nxt;
   logic [CNT_BITS-1:0] r_cnt,      w_cnt_nxt;
   logic [CLR_W-1:0]    r_clr_cnt,  w_clr_cnt_nxt;
   logic                r_out_prev, w_out_prev_nxt;
   logic                r_re,       w_re_nxt;
   logic                r_rstb,     w_rstb_nxt;
   logic                r_valid,    w_valid_nxt;
   logic [CNT_BITS-1:0] r_value,    w_value_nxt;
   logic                r_ovf,      w_ovf_nxt;
   logic                r_tmo,      w_tmo_nxt;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_out (
      .clk (clk),
      .rst (rst),
      .d   (tff_out),
      .q   (w_out_s)
   );

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync_carry (
      .clk (clk),
      .rst (rst),
      .d   (tff_carry),
      .q   (w_carry_s)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_clr_cnt_nxt  = r_clr_cnt;
      w_out_prev_nxt = r_out_prev;
      w_re_nxt       = r_re;
      w_rstb_nxt     = r_rstb;
      w_valid_nxt    = r_valid;
      w_value_nxt    = r_value;
      w_ovf_nxt      = r_ovf;
      w_tmo_nxt      = r_tmo;

      case (r_state)
         ST_CLEAR: begin
            w_re_nxt   = 1'b0;
            w_rstb_nxt = 1'b0;
            if (r_clr_cnt == CLR_LAST) begin
               w_state_nxt   = ST_IDLE;
               w_rstb_nxt    = 1'b1;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            w_rstb_nxt = 1'b1;
            if (start) begin
               w_state_nxt    = ST_READ;
               w_cnt_nxt      = '0;
               w_re_nxt       = 1'b1;
               w_out_prev_nxt = w_out_s;
            end
         end
         ST_READ: begin
            w_out_prev_nxt = w_out_s;
            // Carry outranks a coincident edge; the count is meaningless once the ring wrapped.
            if (w_carry_s) begin
               w_state_nxt = ST_DONE;
               w_re_nxt    = 1'b0;
               w_valid_nxt = 1'b1;
               w_ovf_nxt   = 1'b1;
               w_value_nxt = '1;
            end else if (!r_out_prev && w_out_s) begin
               w_state_nxt = ST_DONE;
               w_re_nxt    = 1'b0;
               w_valid_nxt = 1'b1;
               w_value_nxt = sat_sub_sync(r_cnt);
            end else if (r_cnt == TO_VAL) begin
               w_state_nxt = ST_DONE;
               w_re_nxt    = 1'b0;
               w_valid_nxt = 1'b1;
               w_tmo_nxt   = 1'b1;
               w_value_nxt = '1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            if (ack) begin
               w_state_nxt   = ST_CLEAR;
               w_rstb_nxt    = 1'b0;
               w_clr_cnt_nxt = '0;
               w_valid_nxt   = 1'b0;
               w_value_nxt   = '0;
               w_ovf_nxt     = 1'b0;
               w_tmo_nxt     = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_cnt      <= '0;
         r_clr_cnt  <= '0;
         r_out_prev <= 1'b0;
         r_re       <= 1'b0;
         r_rstb     <= 1'b0;
         r_valid    <= 1'b0;
         r_value    <= '0;
         r_ovf      <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_clr_cnt  <= w_clr_cnt_nxt;
         r_out_prev <= w_out_prev_nxt;
         r_re       <= w_re_nxt;
         r_rstb     <= w_rstb_nxt;
         r_valid    <= w_valid_nxt;
         r_value    <= w_value_nxt;
         r_ovf      <= w_ovf_nxt;
         r_tmo      <= w_tmo_nxt;
      end
   end

   assign RE       = r_re;
   assign rstb     = r_rstb;
   assign busy     = (r_state != ST_IDLE);
   assign valid    = r_valid;
   assign value    = r_value;
   assign overflow = r_ovf;
   assign timeout  = r_tmo;

endmodule

// File: tb/tb_tff_read_decoder.sv
// Directed bench for tff_read_decoder: reset, edge timing, timeout, overflow,
// handshake, saturation at zero and reset during a read.
module tb_tff_read_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       ack;
   logic       tff_out;
   logic       tff_carry;
   logic       RE;
   logic       rstb;
   logic       busy;
   logic       valid;
   logic [7:0] value;
   logic       overflow;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   tff_read_decoder #(
      .CNT_BITS    (8),
      .TIMEOUT     (255),
      .SYNC_STAGES (2),
      .CLR_CYCLES  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ack       (ack),
      .tff_out   (tff_out),
      .tff_carry (tff_carry),
      .RE        (RE),
      .rstb      (rstb),
      .busy      (busy),
      .valid     (valid),
      .value     (value),
      .overflow  (overflow),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic check_result(input string tag, input int lat, input int exp_lat,
                               input logic [7:0] exp_val, input logic exp_ovf, input logic exp_tmo);
      check({tag, "_lat"},   lat,      exp_lat);
      check({tag, "_valid"}, valid,    1'b1);
      check({tag, "_value"}, value,    exp_val);
      check({tag, "_ovf"},   overflow, exp_ovf);
      check({tag, "_tmo"},   timeout,  exp_tmo);
      check({tag, "_re"},    RE,       1'b0);
   endtask

   task automatic finish_result(input string tag, input logic poke_start);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_ack_valid"}, valid,    1'b0);
      check({tag, "_ack_value"}, value,    8'h00);
      check({tag, "_ack_flags"}, {overflow, timeout}, 2'b00);
      check({tag, "_ack_rstb"},  rstb,     1'b0);
      start = poke_start;
      repeat (3) begin
         tick();
         check({tag, "_clr_rstb"}, rstb, 1'b0);
         check({tag, "_clr_busy"}, busy, 1'b1);
      end
      tick();
      start = 1'b0;
      check({tag, "_idle_rstb"}, rstb, 1'b1);
      check({tag, "_idle_busy"}, busy, 1'b0);
      tick();
      check({tag, "_idle_hold_busy"}, busy, 1'b0);
      check({tag, "_idle_hold_re"},   RE,   1'b0);
   endtask

   task automatic normal_read(input string tag);
      int n;
      do_start();
      check({tag, "_re_rise"}, RE, 1'b1);
      check({tag, "_busy"},    busy, 1'b1);
      repeat (10) tick();
      tff_out = 1'b1;
      wait_valid(n);
      check_result(tag, n, 3, 8'd10, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; ack = 1'b0; tff_out = 1'b0; tff_carry = 1'b0;
      #1;
      repeat (2) tick();
      check("rst_re",    RE,       1'b0);
      check("rst_rstb",  rstb,     1'b0);
      check("rst_busy",  busy,     1'b1);
      check("rst_valid", valid,    1'b0);
      check("rst_value", value,    8'h00);
      check("rst_flags", {overflow, timeout}, 2'b00);
      rst = 1'b0;
      repeat (3) tick();
      check("clr3_rstb", rstb, 1'b0);
      check("clr3_busy", busy, 1'b1);
      tick();
      check("clr4_rstb", rstb, 1'b1);
      check("clr4_busy", busy, 1'b0);

      // Normal read, then hold valid while start pulses are ignored.
      normal_read("norm");
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         tick();
         check("hold_valid", valid, 1'b1);
         check("hold_value", value, 8'd10);
         check("hold_re",    RE,    1'b0);
      end
      start = 1'b0;
      tff_out = 1'b0;
      finish_result("norm", 1'b1);

      // Timeout with tff_out low.
      do_start();
      wait_valid(n);
      check_result("tmo", n, 256, 8'hFF, 1'b0, 1'b1);
      finish_result("tmo", 1'b0);

      // Carry wins over a coincident edge.
      do_start();
      repeat (5) tick();
      tff_out = 1'b1;
      tff_carry = 1'b1;
      wait_valid(n);
      check_result("ovf", n, 3, 8'hFF, 1'b1, 1'b0);
      tff_out = 1'b0;
      tff_carry = 1'b0;
      finish_result("ovf", 1'b0);

      // tff_out already high at start: no edge, so it times out.
      tff_out = 1'b1;
      repeat (3) tick();
      do_start();
      wait_valid(n);
      check_result("high", n, 256, 8'hFF, 1'b0, 1'b1);
      tff_out = 1'b0;
      finish_result("high", 1'b0);

      // Edge arriving right after start: count below SYNC_STAGES saturates to 0.
      tff_out = 1'b1;
      do_start();
      wait_valid(n);
      check_result("sat", n, 2, 8'h00, 1'b0, 1'b0);
      tff_out = 1'b0;
      finish_result("sat", 1'b0);

      // Reset in the middle of a read abandons it.
      do_start();
      repeat (5) tick();
      check("mid_re", RE, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_re",    RE,    1'b0);
      check("mid_rst_rstb",  rstb,  1'b0);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_busy",  busy,  1'b1);
      repeat (3) tick();
      check("mid_clr_rstb", rstb, 1'b0);
      tick();
      check("mid_idle_rstb", rstb, 1'b1);
      check("mid_idle_busy", busy, 1'b0);
      normal_read("after_rst");
      tff_out = 1'b0;
      finish_result("after_rst", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
